// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// Runs one bit per clock on operand magnitudes, fixes signs in a final cycle,
// and pulses done with the result and destination register.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op_ex,
  input  logic [XLEN-1:0] rs1Data_ex,
  input  logic [XLEN-1:0] rs2Data_ex,
  input  logic [4:0]      rdAddr_ex,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result_md,
  output logic [4:0]      rdAddr_md
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   a_q;        // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q;      // {hi, multiplier} or {remainder, quotient}
  logic              neg_q;      // negate the selected result in FIX
  logic              spec_q;     // special-case result already in acc_q low half
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rdout_q;

  logic              accept;
  logic              sa, sb, neg_in, div_zero, div_ovf, spec_in;
  logic [XLEN-1:0]   mag1, mag2, spec_val;
  logic [XLEN:0]     mul_sum, div_rem, div_diff;
  logic [2*XLEN-1:0] acc_d, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, fix_res_d;

  // Accept decode: operand signedness, magnitudes and divide special cases.
  always_comb begin
    accept   = start && !flush && (state_q == S_IDLE || state_q == S_DONE);
    sa       = 1'b0;
    sb       = 1'b0;
    case (op_ex)
      3'b001, 3'b100, 3'b110: begin
        sa = rs1Data_ex[XLEN-1];
        sb = rs2Data_ex[XLEN-1];
      end
      3'b010:  sa = rs1Data_ex[XLEN-1];
      default: ;
    endcase
    mag1     = sa ? -rs1Data_ex : rs1Data_ex;
    mag2     = sb ? -rs2Data_ex : rs2Data_ex;
    // Remainder follows the dividend's sign; everything else the sign product.
    neg_in   = (op_ex[2] && op_ex[1]) ? sa : (sa ^ sb);
    div_zero = op_ex[2] && (rs2Data_ex == '0);
    div_ovf  = op_ex[2] && !op_ex[0] && (rs1Data_ex == MIN_NEG) && (rs2Data_ex == '1);
    spec_in  = div_zero || div_ovf;
    if (div_zero) spec_val = op_ex[1] ? rs1Data_ex : '1;
    else          spec_val = op_ex[1] ? '0 : MIN_NEG;
  end

  // One shift-add or restoring-divide step, and the FIX-cycle result select.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? a_q : '0)};
    div_rem  = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_rem - {1'b0, a_q};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                 acc_d = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod_s = neg_q ? -acc_q : acc_q;
    quot_s = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (spec_q)            fix_res_d = acc_q[XLEN-1:0];
    else if (op_q[2])      fix_res_d = op_q[1] ? rem_s : quot_s;
    else if (op_q == 3'b000) fix_res_d = prod_s[XLEN-1:0];
    else                   fix_res_d = prod_s[2*XLEN-1:XLEN];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state and status outputs; flush overrides everything.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: state_d = accept ? (spec_in ? S_FIX : S_CALC) : S_IDLE;
      S_CALC:         if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIX;
      S_FIX:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
    busy = (state_q == S_CALC) || (state_q == S_FIX);
    done = (state_q == S_DONE);
  end

  // Datapath: latch on accept, iterate in CALC, load result in FIX.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      result_q <= '0;
      rdout_q  <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      op_q   <= op_ex;
      rd_q   <= rdAddr_ex;
      a_q    <= op_ex[2] ? mag2 : mag1;
      acc_q  <= spec_in ? {{XLEN{1'b0}}, spec_val}
                        : {{XLEN{1'b0}}, (op_ex[2] ? mag1 : mag2)};
      neg_q  <= neg_in;
      spec_q <= spec_in;
    end else if (!flush) begin
      if (state_q == S_CALC) begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= acc_d;
      end
      if (state_q == S_FIX) begin
        result_q <= fix_res_d;
        rdout_q  <= rd_q;
      end
    end
  end

  assign result_md = result_q;
  assign rdAddr_md = rdout_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vectors with hand-computed results for ex_muldiv.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op_ex = '0;
  logic [31:0] rs1Data_ex = '0;
  logic [31:0] rs2Data_ex = '0;
  logic [4:0]  rdAddr_ex = '0;
  logic        busy, done;
  logic [31:0] result_md;
  logic [4:0]  rdAddr_md;

  int errors = 0;
  int checks = 0;

  ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op_ex(op_ex),
    .rs1Data_ex(rs1Data_ex), .rs2Data_ex(rs2Data_ex), .rdAddr_ex(rdAddr_ex),
    .busy(busy), .done(done), .result_md(result_md), .rdAddr_md(rdAddr_md)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives one start cycle and returns at cycle 1 after accept.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    start = 1'b1; op_ex = op; rs1Data_ex = a; rs2Data_ex = b; rdAddr_ex = rd;
    @(negedge clk);
    start = 1'b0; rs1Data_ex = 32'h1234_5678; rs2Data_ex = 32'h0BAD_F00D;
  endtask

  task automatic wait_done(output int lat, output int busyc);
    lat = 1; busyc = 0;
    while (!done && lat < 100) begin
      if (busy) busyc++;
      @(negedge clk);
      lat++;
    end
    if (busy) busyc++;
  endtask

  // Ends at the negedge of the DONE cycle.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_lat);
    int lat, busyc;
    start_op(op, a, b, rd);
    wait_done(lat, busyc);
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".res"}, result_md, exp);
    chk({tag, ".rd"}, {27'd0, rdAddr_md}, {27'd0, rd});
    chk({tag, ".busy"}, busyc, exp_lat - 1);
  endtask

  initial begin
    int pulses;
    #12;
    chk("rst.busy", {31'd0, busy}, 0);
    chk("rst.done", {31'd0, done}, 0);
    chk("rst.res", result_md, 0);
    chk("rst.rd", {27'd0, rdAddr_md}, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    do_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34); @(negedge clk);
    do_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 34); @(negedge clk);
    do_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 34); @(negedge clk);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 34); @(negedge clk);
    do_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,        5'd9,  32'hFFFF_FFFD, 34); @(negedge clk);
    do_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        5'd10, 32'hFFFF_FFFF, 34); @(negedge clk);
    do_op("divu",   3'b101, 32'd100,      32'd7,        5'd11, 32'd14,        34); @(negedge clk);
    do_op("remu",   3'b111, 32'd100,      32'd7,        5'd12, 32'd2,         34); @(negedge clk);
    do_op("divu0",  3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFF_FFFF, 2);  @(negedge clk);
    do_op("rem0",   3'b110, 32'd5,        32'd0,        5'd14, 32'd5,         2);  @(negedge clk);
    do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 2);  @(negedge clk);
    do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         2);  @(negedge clk);

    // Flush at cycle 10 of a DIV, with a start in the same cycle.
    start_op(3'b100, 32'd1000, 32'd3, 5'd17);
    repeat (9) @(negedge clk);
    flush = 1'b1; start = 1'b1; op_ex = 3'b101; rs1Data_ex = 32'd50; rs2Data_ex = 32'd5;
    @(negedge clk);
    chk("flush.busy", {31'd0, busy}, 0);
    chk("flush.done", {31'd0, done}, 0);
    chk("flush.res", result_md, 32'd0);
    chk("flush.rd", {27'd0, rdAddr_md}, 32'd16);
    @(negedge clk);
    chk("flush.drop", {31'd0, busy}, 0);
    flush = 1'b0; start = 1'b0;
    pulses = 0;
    repeat (3) begin @(negedge clk); if (done) pulses++; end
    chk("flush.nodone", pulses, 0);
    do_op("after", 3'b101, 32'd50, 32'd5, 5'd18, 32'd10, 34); @(negedge clk);

    // Asynchronous reset mid-CALC.
    start_op(3'b000, 32'd3, 32'd4, 5'd19);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst.busy", {31'd0, busy}, 0);
    chk("arst.done", {31'd0, done}, 0);
    chk("arst.res", result_md, 0);
    chk("arst.rd", {27'd0, rdAddr_md}, 0);
    @(negedge clk); reset = 1'b1;
    pulses = 0;
    repeat (40) begin @(negedge clk); if (done || busy) pulses++; end
    chk("arst.quiet", pulses, 0);

    // Back-to-back: second start in the DONE cycle of the first.
    do_op("b2b1", 3'b000, 32'd1000, 32'd1000, 5'd20, 32'd1000000, 34);
    do_op("b2b2", 3'b111, 32'd1000, 32'd7,    5'd21, 32'd6,       34);
    @(negedge clk);
    chk("end.idle", {30'd0, busy, done}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
